ad_conv_sched: RTL and testbench
================================

AD_CONV_SCHED -- requirements
Module: ad_conv_sched

Interface
REQ-001 Parameter NCH, default 4, number of sample-request channels.
REQ-002 Parameter DW, default 16, ADC result width.
REQ-003 Parameter CONVST_W, default 4, convst pulse width in clk cycles (>=1).
REQ-004 Parameter BUSY_TMO, default 255, max cycles waiting for adc_busy low.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  scheduler enable; low blocks new grants.
REQ-008 ad_start  in  NCH  per-channel sample requests; each request is a rising edge.
REQ-009 adc_convst  out  1  conversion-start strobe to the shared ADC.
REQ-010 adc_busy  in  1  ADC converting; high while conversion runs.
REQ-011 rd_req  out  1  readout request to the serial reader.
REQ-012 rd_ch  out  log2(NCH)  channel tag of the current readout.
REQ-013 rd_ack  in  1  reader done; rd_data valid in the same cycle.
REQ-014 rd_data  in  DW  conversion result.
REQ-015 smp_valid  out  1  one-cycle sample strobe.
REQ-016 smp_ch  out  log2(NCH)  channel of the sample.
REQ-017 smp_data  out  DW  sample value.
REQ-018 ovr_flag  out  NCH  sticky per-channel overrun flags.
REQ-019 tmo_flag  out  1  sticky busy-timeout flag.
REQ-020 flag_clr  in  1  synchronous clear of ovr_flag and tmo_flag.

Function
REQ-021 ad_start SHALL be registered once; a request is prev=0, cur=1 on the registered copy.
REQ-022 A request on channel i SHALL set pend[i]; if pend[i] is already 1 and is not granted that cycle, ovr_flag[i] SHALL set.
REQ-023 A request in the same cycle as the grant of i SHALL leave pend[i]=1, with no overrun.
REQ-024 FSM states SHALL be IDLE, CONV, WAIT, READ.
REQ-025 IDLE: when enable=1 and pend!=0, grant round-robin starting at (last_grant+1) mod NCH, clear pend[grant], latch the channel and go to CONV.
REQ-026 CONV: adc_convst SHALL be high for exactly CONVST_W cycles, then go to WAIT.
REQ-027 WAIT: on adc_busy=0, go to READ.
- WAIT timeout: if BUSY_TMO cycles elapse in WAIT, set tmo_flag, go to IDLE, produce no sample.
REQ-028 READ: rd_req=1 and rd_ch=latched channel, held until rd_ack.
- On rd_ack, in the next cycle: smp_valid=1, smp_ch=latched channel, smp_data=captured rd_data; FSM returns to IDLE.
REQ-029 Minimum request-edge to convst-high latency SHALL be 2 cycles: 1 cycle edge register, 1 cycle IDLE grant.
REQ-030 enable=0 SHALL clear all pend bits and block grants; a conversion in progress SHALL complete normally.
REQ-031 flag_clr SHALL take priority over flag sets in the same cycle.
REQ-032 last_grant SHALL update only on grant; its reset value is NCH-1, so channel 0 is first.
REQ-033 smp_data and smp_ch SHALL hold their values between strobes.

Reset
REQ-034 Asynchronous reset SHALL force:
- FSM to IDLE;
- pend, ovr_flag, tmo_flag, adc_convst, rd_req, smp_valid, smp_data, smp_ch and rd_ch to 0;
- the edge register to all-ones, so that requests already high at reset exit are not counted as edges;
- last_grant to NCH-1.
REQ-035 Reset mid-conversion SHALL drop adc_convst and rd_req immediately, with no sample emitted.

Structure
REQ-036 Package ad_pkg SHALL hold the FSM state enum, the NCH/DW defaults and a clog2 helper constant.
REQ-037 Round-robin selection SHALL be one sub-module, rr_arb (req, last_grant -> grant index, any).

Verification
REQ-038 Single request: ch2 edge with BUSY low 10 cycles after convst -> convst high 4 cycles; rd_req with rd_ch=2; rd_ack rd_data=0x1234 -> smp_valid one cycle, smp_ch=2, smp_data=0x1234.
REQ-039 Simultaneous edges on ch0..3 in one cycle -> four samples in order 0,1,2,3; no ovr_flag bits set.
REQ-040 Round-robin: after ch1 is granted, edges on ch0 and ch3 together -> ch3 is served before ch0.
REQ-041 Overrun: two ch1 edges while ch0 is converting -> ovr_flag=4'b0010 and only one ch1 sample; flag_clr -> ovr_flag=0.
REQ-042 Timeout: adc_busy held high -> after 255 WAIT cycles, tmo_flag=1, no smp_valid, FSM in IDLE, next pending channel granted.
REQ-043 Reset/enable: rst_n low during READ -> rd_req=0 within the same cycle; enable=0 with pend=4'b1010 -> pend cleared, no convst.

Source files
------------

// File: rtl/ad_pkg.sv
// ad_pkg: shared FSM state type, default sizes and channel-index width helper
package ad_pkg;
    typedef enum logic [1:0] {IDLE, CONV, WAIT, READ} state_t;
    localparam int NCH_DEF = 4;
    localparam int DW_DEF = 16;
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int CHW_DEF = clog2w(NCH_DEF);
endpackage

// File: rtl/ad_conv_sched_rr_arb.sv
// rr_arb: round-robin pick of the first requester after last_grant
module rr_arb import ad_pkg::*; #(
    parameter int N = NCH_DEF,
    parameter int W = CHW_DEF
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any
);
    logic [W-1:0] idx;
    // Walk from farthest to nearest so the nearest requester after last_grant wins
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(last_grant) + k) % N);
            if (req[idx]) grant = idx;
        end
    end
    assign any = |req;
endmodule

// File: rtl/ad_conv_sched.sv
// ad_conv_sched: round-robin scheduler sharing one ADC among NCH sample-request channels
module ad_conv_sched import ad_pkg::*; #(
    parameter int NCH = NCH_DEF,
    parameter int DW = DW_DEF,
    parameter int CONVST_W = 4,
    parameter int BUSY_TMO = 255,
    localparam int CW = clog2w(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [NCH-1:0] ad_start,
    output logic           adc_convst,
    input  logic           adc_busy,
    output logic           rd_req,
    output logic [CW-1:0]  rd_ch,
    input  logic           rd_ack,
    input  logic [DW-1:0]  rd_data,
    output logic           smp_valid,
    output logic [CW-1:0]  smp_ch,
    output logic [DW-1:0]  smp_data,
    output logic [NCH-1:0] ovr_flag,
    output logic           tmo_flag,
    input  logic           flag_clr
);
    localparam int TMAX = (CONVST_W > BUSY_TMO) ? CONVST_W : BUSY_TMO;
    localparam int TW = clog2w(TMAX + 1);
    state_t state;
    logic [NCH-1:0] ad_q, pend, edge_v, gmask, ovr_set;
    logic [CW-1:0] last_grant, gnt;
    logic [TW-1:0] cnt;
    logic any, grant_fire, tmo_hit;

    rr_arb #(.N(NCH), .W(CW)) u_arb (
        .req(pend),
        .last_grant(last_grant),
        .grant(gnt),
        .any(any)
    );

    always_comb begin
        gmask = '0;
        gmask[gnt] = grant_fire;
    end

    assign edge_v = ad_start & ~ad_q;
    assign grant_fire = state == IDLE && enable && any;
    // An edge landing on the very cycle its channel is granted re-arms pend without overrun
    assign ovr_set = edge_v & pend & ~gmask;
    assign tmo_hit = state == WAIT && adc_busy && cnt == TW'(BUSY_TMO - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ad_q <= '1;
            pend <= '0;
            ovr_flag <= '0;
            tmo_flag <= 1'b0;
            adc_convst <= 1'b0;
            rd_req <= 1'b0;
            rd_ch <= '0;
            smp_valid <= 1'b0;
            smp_ch <= '0;
            smp_data <= '0;
            last_grant <= CW'(NCH - 1);
            cnt <= '0;
        end else begin
            ad_q <= ad_start;
            pend <= enable ? (pend & ~gmask) | edge_v : '0;
            ovr_flag <= flag_clr ? '0 : ovr_flag | ovr_set;
            tmo_flag <= !flag_clr && (tmo_flag || tmo_hit);
            smp_valid <= 1'b0;
            case (state)
                IDLE: if (grant_fire) begin
                    state <= CONV;
                    rd_ch <= gnt;
                    last_grant <= gnt;
                    adc_convst <= 1'b1;
                    cnt <= '0;
                end
                CONV: if (cnt == TW'(CONVST_W - 1)) begin
                    state <= WAIT;
                    adc_convst <= 1'b0;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
                WAIT: if (!adc_busy) begin
                    state <= READ;
                    rd_req <= 1'b1;
                end else if (tmo_hit) state <= IDLE;
                else cnt <= cnt + 1'b1;
                READ: if (rd_ack) begin
                    state <= IDLE;
                    rd_req <= 1'b0;
                    smp_valid <= 1'b1;
                    smp_ch <= rd_ch;
                    smp_data <= rd_data;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad_conv_sched.sv
// tb_ad_conv_sched: scoreboard bench with ADC/reader models and a round-robin service-order model
module tb_ad_conv_sched;
    localparam int NCH = 4;
    localparam int DW = 16;
    logic clk = 0, rst_n = 0, enable = 0, flag_clr = 0, adc_busy = 0, rd_ack = 0;
    logic [NCH-1:0] ad_start = '0;
    logic [DW-1:0] rd_data = '0;
    logic adc_convst, rd_req, smp_valid, tmo_flag;
    logic [1:0] rd_ch, smp_ch;
    logic [DW-1:0] smp_data;
    logic [NCH-1:0] ovr_flag;
    typedef struct { int ch; logic [DW-1:0] d; } exp_t;
    exp_t exp_q[$];
    logic [DW-1:0] data_q[$];
    int errors = 0, checks = 0, m_last = NCH - 1, busy_len = 4, conv_cnt = 0, hi = 0, ack_dly = 0;
    bit busy_stuck = 0, rd_hold = 0;

    ad_conv_sched #(.NCH(NCH), .DW(DW), .CONVST_W(4), .BUSY_TMO(255)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ad_start(ad_start),
        .adc_convst(adc_convst), .adc_busy(adc_busy), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_ack(rd_ack), .rd_data(rd_data), .smp_valid(smp_valid), .smp_ch(smp_ch),
        .smp_data(smp_data), .ovr_flag(ovr_flag), .tmo_flag(tmo_flag), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_grant(input int c, input bit smp, input logic [DW-1:0] d);
        m_last = c;
        if (smp) begin
            data_q.push_back(d);
            exp_q.push_back('{c, d});
        end
    endtask

    // Channels raised together while idle are served in rotation order after the last grant
    task automatic issue(input logic [NCH-1:0] mask);
        int base, c;
        base = m_last;
        for (int k = 1; k <= NCH; k++) begin
            c = (base + k) % NCH;
            if (mask[2'(c)]) note_grant(c, 1, DW'($urandom));
        end
        @(posedge clk);
        #1 ad_start = ad_start | mask;
    endtask

    task automatic release_all();
        @(posedge clk);
        #1 ad_start = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(exp_q.size()), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_convst(input logic lvl, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (adc_convst !== lvl && n < 600);
        check(name, 32'(adc_convst), 32'(lvl));
    endtask

    // ADC: busy rises with convst and falls busy_len cycles after convst ends unless stuck
    initial forever begin
        @(posedge adc_convst);
        #1 adc_busy = 1;
        @(negedge adc_convst);
        repeat (busy_len) @(posedge clk);
        #1 adc_busy = busy_stuck;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rd_ack) rd_ack = 0;
        else if (rd_req && rst_n && !rd_hold) begin
            if (ack_dly > 0) ack_dly--;
            else begin
                if (exp_q.size() != 0) check("rd_ch", 32'(rd_ch), 32'(exp_q[0].ch));
                if (data_q.size() != 0) rd_data = data_q.pop_front();
                else rd_data = '0;
                rd_ack = 1;
                ack_dly = $urandom_range(0, 3);
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) hi = 0;
        else begin
            if (adc_convst) begin
                if (hi == 0) conv_cnt++;
                hi++;
            end else if (hi != 0) begin
                check("convst_width", 32'(hi), 4);
                hi = 0;
            end
            if (smp_valid) begin
                if (exp_q.size() == 0) check("unexpected_smp", 32'(smp_valid), 0);
                else begin
                    e = exp_q.pop_front();
                    check("smp_ch", 32'(smp_ch), 32'(e.ch));
                    check("smp_data", 32'(smp_data), 32'(e.d));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {24'b0, adc_convst, rd_req, smp_valid, tmo_flag, ovr_flag}, 0);
        check("reset_ch", {28'b0, rd_ch, smp_ch}, 0);
        check("reset_data", 32'(smp_data), 0);
        ad_start = 4'b1000;
        @(posedge clk);
        #1 rst_n = 1;
        enable = 1;
        repeat (8) @(negedge clk);
        check("no_edge_at_reset_exit", 32'(conv_cnt), 0);
        release_all();
        busy_len = 10;
        note_grant(2, 1, 16'h1234);
        @(posedge clk);
        #1 ad_start = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check("latency_pre", 32'(adc_convst), 0);
        @(posedge clk);
        @(negedge clk);
        check("latency_convst", 32'(adc_convst), 1);
        wait_done("single_ch2");
        release_all();
        issue(4'b1000);
        wait_done("ch3");
        release_all();
        issue(4'b1111);
        wait_done("all4");
        check("all4_no_ovr", 32'(ovr_flag), 0);
        release_all();
        issue(4'b0010);
        wait_done("rr_ch1");
        release_all();
        issue(4'b1001);
        wait_done("rr_3_then_0");
        release_all();
        for (int r = 0; r < 16; r++) begin
            busy_len = $urandom_range(1, 12);
            issue(4'($urandom_range(1, 15)));
            wait_done("random");
            release_all();
        end
        check("random_no_ovr", 32'(ovr_flag), 0);
        busy_len = 20;
        issue(4'b0001);
        wait_convst(1, "ovr_convst");
        @(posedge clk);
        #1 ad_start = 4'b0011;
        note_grant(1, 1, DW'($urandom));
        @(posedge clk);
        #1 ad_start = 4'b0001;
        @(posedge clk);
        #1 ad_start = 4'b0011;
        wait_done("overrun");
        check("ovr_flag_set", 32'(ovr_flag), 32'b0010);
        @(posedge clk);
        #1 flag_clr = 1;
        @(posedge clk);
        #1 flag_clr = 0;
        @(negedge clk);
        check("ovr_flag_clr", 32'(ovr_flag), 0);
        release_all();
        busy_len = 1;
        busy_stuck = 1;
        note_grant(2, 0, '0);
        note_grant(3, 1, DW'($urandom));
        @(posedge clk);
        #1 ad_start = 4'b1100;
        wait_convst(1, "tmo_convst");
        wait_convst(0, "tmo_wait_entry");
        n = 0;
        while (!tmo_flag && n < 400) begin
            @(negedge clk);
            n++;
        end
        busy_stuck = 0;
        check("tmo_wait_cycles", 32'(n), 255);
        check("tmo_flag_set", 32'(tmo_flag), 1);
        @(negedge clk);
        check("tmo_next_grant", 32'(adc_convst), 1);
        wait_done("after_tmo");
        check("tmo_sticky", 32'(tmo_flag), 1);
        @(posedge clk);
        #1 flag_clr = 1;
        @(posedge clk);
        #1 flag_clr = 0;
        @(negedge clk);
        check("tmo_flag_clr", 32'(tmo_flag), 0);
        release_all();
        rd_hold = 1;
        busy_len = 3;
        issue(4'b0001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_req && n < 200);
        check("rd_req_seen", 32'(rd_req), 1);
        c0 = conv_cnt;
        #2 rst_n = 0;
        #1;
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_convst", 32'(adc_convst), 0);
        exp_q.delete();
        data_q.delete();
        m_last = NCH - 1;
        ad_start = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        rd_hold = 0;
        repeat (12) @(negedge clk);
        check("rst_no_new_conv", 32'(conv_cnt), 32'(c0));
        busy_len = 20;
        issue(4'b0001);
        wait_convst(1, "en_convst");
        @(posedge clk);
        #1 ad_start = 4'b1011;
        @(posedge clk);
        #1 enable = 0;
        wait_done("en_inflight");
        c0 = conv_cnt;
        repeat (5) @(posedge clk);
        #1 enable = 1;
        repeat (20) @(negedge clk);
        check("en_pend_cleared", 32'(conv_cnt), 32'(c0));
        check("en_no_ovr", 32'(ovr_flag), 0);
        release_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
